// File: rtl/cache_set_lookup_pkg.sv
// Shared types and constants for the cache set lookup stage.
//   mesi_t       : per-line coherence state
//   cache_line_t : tag + state as exchanged with mesi_fsm (tag field is
//                  wide enough for any legal TAG_W; unused upper bits are zero)
//   command_t    : trace command code plus 32-bit address
//   state_t      : lookup-stage FSM states
package my_struct_package;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        E = 2'd2,
        M = 2'd3
    } mesi_t;

    localparam int LINE_TAG_W = 32;

    typedef struct packed {
        logic [LINE_TAG_W-1:0] tag;
        mesi_t                 mesi;
    } cache_line_t;

    typedef struct packed {
        logic [3:0]  n;
        logic [31:0] addr;
    } command_t;

    localparam logic [3:0] READ       = 4'd0;
    localparam logic [3:0] WRITE      = 4'd1;
    localparam logic [3:0] IFETCH     = 4'd2;
    localparam logic [3:0] SNOOP_INV  = 4'd3;
    localparam logic [3:0] SNOOP_RD   = 4'd4;
    localparam logic [3:0] SNOOP_WR   = 4'd5;
    localparam logic [3:0] SNOOP_RWIM = 4'd6;
    localparam logic [3:0] CLEAR      = 4'd8;
    localparam logic [3:0] PRINT      = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_PRESENT,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/cache_set_lookup_if.sv
// Command / lookup / write-back bundle between the trace driver, this stage
// and mesi_fsm.
//   master : drives cmd_valid, cmd, wb_valid, return_line
//   slave  : drives cmd_ready, lu_valid, hit, hitM, way, internal_line,
//            clear_done
interface cache_set_lookup_if #(
    parameter int WAYS = 8
) ();
    import my_struct_package::*;

    localparam int WAY_W = $clog2(WAYS);

    logic              cmd_valid;
    logic              cmd_ready;
    command_t          cmd;
    logic              lu_valid;
    logic              hit;
    logic              hitM;
    logic [WAY_W-1:0]  way;
    cache_line_t       internal_line;
    logic              wb_valid;
    cache_line_t       return_line;
    logic              clear_done;

    modport master (
        output cmd_valid, cmd, wb_valid, return_line,
        input  cmd_ready, lu_valid, hit, hitM, way, internal_line, clear_done
    );

    modport slave (
        input  cmd_valid, cmd, wb_valid, return_line,
        output cmd_ready, lu_valid, hit, hitM, way, internal_line, clear_done
    );

endinterface

// File: rtl/cache_set_lookup_plru_tree.sv
// Tree pseudo-LRU for one set (purely combinational).
//   plru       : WAYS-1 heap-ordered node bits (root at 0, children 2k+1/2k+2);
//                a 0 bit means the victim lies in the lower half
//   access_way : way being touched
//   victim     : way selected by following the node bits from the root
//   plru_next  : plru with every node on access_way's path pointing away
module plru_tree #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-2:0]         plru,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         plru_next
);
    localparam int LEVELS = $clog2(WAYS);
    localparam int NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

    logic [NODE_W-1:0] vic_node;
    logic [NODE_W-1:0] acc_node;
    logic              acc_bit;

    always_comb begin
        victim   = '0;
        vic_node = '0;
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            victim[LEVELS-1-lvl] = plru[vic_node];
            // child index = 2*node + 1 + direction
            vic_node = NODE_W'({vic_node, 1'b1} + {{NODE_W{1'b0}}, plru[vic_node]});
        end
    end

    always_comb begin
        plru_next = plru;
        acc_node  = '0;
        acc_bit   = 1'b0;
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            acc_bit             = access_way[LEVELS-1-lvl];
            plru_next[acc_node] = ~acc_bit;
            acc_node = NODE_W'({acc_node, 1'b1} + {{NODE_W{1'b0}}, acc_bit});
        end
    end

endmodule

// File: rtl/cache_set_lookup.sv
// Tag lookup and replacement stage feeding mesi_fsm. Owns the tag, state and
// PLRU arrays; runs one command at a time (IDLE -> LOOKUP -> PRESENT) and
// executes the clear command as a one-set-per-cycle sweep.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset; reinitialises the whole array
//   bus  : cache_set_lookup_if slave (command in, lookup result out,
//          write-back in, clear_done pulse out)
module cache_set_lookup
    import my_struct_package::*;
#(
    parameter int WAYS  = 8,
    parameter int IDX_W = 14,
    parameter int TAG_W = 12,
    parameter int OFF_W = 6
) (
    input logic              clk,
    input logic              rst,
    cache_set_lookup_if.slave bus
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int SETS   = 2 ** IDX_W;
    localparam int PLRU_W = WAYS - 1;

    logic [WAYS-1:0][TAG_W-1:0] tag_q  [SETS];
    logic [WAYS-1:0][1:0]       mesi_q [SETS];
    logic [PLRU_W-1:0]          plru_q [SETS];

    state_t            state_q, state_d;
    command_t          cmd_q, cmd_d;
    logic              hit_q, hit_d;
    logic              hitm_q, hitm_d;
    logic [WAY_W-1:0]  way_q, way_d;
    cache_line_t       line_q, line_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              clear_done_q, clear_done_d;

    logic [IDX_W-1:0]           cur_idx;
    logic [TAG_W-1:0]           cur_tag;
    logic [WAYS-1:0][TAG_W-1:0] set_tags;
    logic [WAYS-1:0][1:0]       set_mesi;
    logic [PLRU_W-1:0]          set_plru;
    logic                       match_found, inv_found;
    logic [WAY_W-1:0]           match_way, inv_way, victim, sel_way;
    logic [PLRU_W-1:0]          plru_upd;
    logic                       wr_line, wr_plru, wr_clear;
    logic                       unused_bits;

    // cmd_q is stable from LOOKUP through PRESENT, so the same index serves
    // both the read and the write-back.
    assign cur_idx  = cmd_q.addr[OFF_W+IDX_W-1:OFF_W];
    assign cur_tag  = cmd_q.addr[31:32-TAG_W];
    assign set_tags = tag_q[cur_idx];
    assign set_mesi = mesi_q[cur_idx];
    assign set_plru = plru_q[cur_idx];

    assign unused_bits = ^{cmd_q.addr[OFF_W-1:0], bus.return_line.tag[LINE_TAG_W-1:TAG_W]};

    always_comb begin
        match_found = 1'b0;
        match_way   = '0;
        inv_found   = 1'b0;
        inv_way     = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!match_found && set_mesi[w] != I && set_tags[w] == cur_tag) begin
                match_found = 1'b1;
                match_way   = WAY_W'(w);
            end
            if (!inv_found && set_mesi[w] == I) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        sel_way = match_found ? match_way : (inv_found ? inv_way : victim);
    end

    // Victim is only consumed in LOOKUP, the update only in PRESENT, where
    // way_q already holds the way being written.
    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru       (set_plru),
        .access_way (way_q),
        .victim     (victim),
        .plru_next  (plru_upd)
    );

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        hit_d        = hit_q;
        hitm_d       = hitm_q;
        way_d        = way_q;
        line_d       = line_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = 1'b0;
        wr_line      = 1'b0;
        wr_plru      = 1'b0;
        wr_clear     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d = bus.cmd;
                    // PRINT and unknown codes are consumed without leaving IDLE
                    if (bus.cmd.n == CLEAR) begin
                        state_d = ST_CLEAR;
                    end else if (bus.cmd.n <= SNOOP_RWIM) begin
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                hit_d   = match_found;
                hitm_d  = match_found && (set_mesi[match_way] == M);
                way_d   = sel_way;
                line_d  = '{tag: LINE_TAG_W'(set_tags[sel_way]), mesi: mesi_t'(set_mesi[sel_way])};
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.wb_valid) begin
                    wr_line = 1'b1;
                    wr_plru = (cmd_q.n <= IFETCH) && (bus.return_line.mesi != I);
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                wr_clear = 1'b1;
                if (clr_cnt_q == '1) begin
                    clr_cnt_d    = '0;
                    clear_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            hit_q        <= 1'b0;
            hitm_q       <= 1'b0;
            way_q        <= '0;
            line_q       <= '0;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            hit_q        <= hit_d;
            hitm_q       <= hitm_d;
            way_q        <= way_d;
            line_q       <= line_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q  <= '{default: '0};
            mesi_q <= '{default: '0};
            plru_q <= '{default: '0};
        end else begin
            if (wr_clear) begin
                tag_q[clr_cnt_q]  <= '0;
                mesi_q[clr_cnt_q] <= '0;
                plru_q[clr_cnt_q] <= '0;
            end
            if (wr_line) begin
                tag_q[cur_idx][way_q]  <= bus.return_line.tag[TAG_W-1:0];
                mesi_q[cur_idx][way_q] <= bus.return_line.mesi;
            end
            if (wr_plru) begin
                plru_q[cur_idx] <= plru_upd;
            end
        end
    end

    assign bus.cmd_ready     = (state_q == ST_IDLE);
    assign bus.lu_valid      = (state_q == ST_PRESENT);
    assign bus.hit           = hit_q;
    assign bus.hitM          = hitm_q;
    assign bus.way           = way_q;
    assign bus.internal_line = line_q;
    assign bus.clear_done    = clear_done_q;

endmodule

// File: tb/tb_cache_set_lookup.sv
// Self-checking bench for cache_set_lookup: directed scenario on set 0x3784,
// randomized command mix over a few sets, clear sweep and mid-sweep reset,
// all checked against an array-based reference of the cache contents.
module tb_cache_set_lookup;
    import my_struct_package::*;

    localparam int WAYS  = 8;
    localparam int IDX_W = 14;
    localparam int TAG_W = 12;
    localparam int OFF_W = 6;
    localparam int SETS  = 1 << IDX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cache_set_lookup_if #(.WAYS(WAYS)) bus ();

    cache_set_lookup #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .OFF_W (OFF_W)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    // Reference contents; tree nodes kept 1-based (root 1, children 2n/2n+1)
    // and stored at [node-1].
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    mesi_t            m_state [SETS][WAYS];
    bit               m_tree  [SETS][WAYS-1];

    function automatic void model_reset();
        for (int unsigned si = 0; si < SETS; si++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                m_tag[si][w]   = '0;
                m_state[si][w] = I;
            end
            for (int unsigned nd = 0; nd < WAYS - 1; nd++) m_tree[si][nd] = 1'b0;
        end
    endfunction

    // Narrow the range [lo, lo+size) by halving until one way remains.
    function automatic int model_victim(int si);
        int lo = 0;
        int size = WAYS;
        int node = 1;
        while (size > 1) begin
            size = size / 2;
            if (m_tree[si][node-1]) begin
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                node = 2 * node;
            end
        end
        return lo;
    endfunction

    function automatic void model_touch(int si, int w);
        int lo = 0;
        int size = WAYS;
        int node = 1;
        while (size > 1) begin
            size = size / 2;
            if (w >= lo + size) begin
                m_tree[si][node-1] = 1'b0;
                lo   = lo + size;
                node = 2 * node + 1;
            end else begin
                m_tree[si][node-1] = 1'b1;
                node = 2 * node;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_cmd_ready",  64'(bus.cmd_ready), 64'(1));
        check("rst_lu_valid",   64'(bus.lu_valid), 64'(0));
        check("rst_hit",        64'(bus.hit), 64'(0));
        check("rst_hitM",       64'(bus.hitM), 64'(0));
        check("rst_way",        64'(bus.way), 64'(0));
        check("rst_line",       64'(bus.internal_line), 64'(0));
        check("rst_clear_done", 64'(bus.clear_done), 64'(0));
    endtask

    // mode 0: return {addr tag, rstate}; mode 1: return presented line unchanged;
    // mode 2: like mode 0 on a hit, unchanged on a miss.
    task automatic run_cmd(input logic [3:0] n, input logic [31:0] addr, input int mode,
                           input mesi_t rstate, output logic o_hit, output logic o_hitm,
                           output logic [2:0] o_way, output cache_line_t o_line);
        int               si;
        logic [TAG_W-1:0] tg;
        bit               e_hit;
        int               e_way;
        cache_line_t      e_line;
        cache_line_t      ret;
        int               waited;
        int               hold;
        si     = int'(addr[OFF_W+IDX_W-1:OFF_W]);
        tg     = addr[31:32-TAG_W];
        e_hit  = 1'b0;
        e_way  = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (e_way < 0 && m_state[si][w] != I && m_tag[si][w] == tg) begin
                e_hit = 1'b1;
                e_way = w;
            end
        end
        if (!e_hit) begin
            for (int w = 0; w < WAYS; w++) if (e_way < 0 && m_state[si][w] == I) e_way = w;
            if (e_way < 0) e_way = model_victim(si);
        end
        e_line = '{tag: 32'(m_tag[si][e_way]), mesi: m_state[si][e_way]};

        // stray write-back while not presenting must be ignored
        bus.wb_valid    = 1'($urandom_range(0, 1));
        bus.return_line = {$urandom, 2'($urandom)};
        @(negedge clk);
        check("ready_before_cmd", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd       = '{n: n, addr: addr};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd       = {$urandom, 4'($urandom)};
        check("ready_in_lookup", 64'(bus.cmd_ready), 64'(0));
        check("lu_valid_in_lookup", 64'(bus.lu_valid), 64'(0));
        @(negedge clk);
        bus.wb_valid = 1'b0;
        check("lu_valid_latency", 64'(bus.lu_valid), 64'(1));
        waited = 0;
        while (!bus.lu_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        o_hit  = bus.hit;
        o_hitm = bus.hitM;
        o_way  = bus.way;
        o_line = bus.internal_line;
        if (!bus.lu_valid) begin
            errors++;
            checks++;
            $display("FAIL lu_valid_timeout: got 0 expected 1 within 8 cycles at %0t", $time);
            return;
        end

        hold = $urandom_range(0, 2);
        for (int c = 0; c <= hold; c++) begin
            if (c > 0) @(negedge clk);
            check("hit",  64'(bus.hit), 64'(e_hit));
            check("hitM", 64'(bus.hitM), 64'(e_hit && e_line.mesi == M));
            check("way",  64'(bus.way), 64'(e_way));
            check("internal_line", 64'(bus.internal_line), 64'(e_line));
            check("lu_valid_hold", 64'(bus.lu_valid), 64'(1));
            check("ready_in_present", 64'(bus.cmd_ready), 64'(0));
        end

        if (mode == 1 || (mode == 2 && !e_hit)) ret = e_line;
        else ret = '{tag: 32'(tg), mesi: rstate};
        bus.wb_valid    = 1'b1;
        bus.return_line = ret;
        @(negedge clk);
        bus.wb_valid    = 1'b0;
        bus.return_line = {$urandom, 2'($urandom)};
        check("ready_after_wb", 64'(bus.cmd_ready), 64'(1));
        check("lu_valid_after_wb", 64'(bus.lu_valid), 64'(0));

        m_tag[si][e_way]   = ret.tag[TAG_W-1:0];
        m_state[si][e_way] = ret.mesi;
        if (n <= IFETCH && ret.mesi != I) model_touch(si, e_way);
    endtask

    task automatic run_nop(input logic [3:0] n, input logic [31:0] addr);
        @(negedge clk);
        check("nop_ready_before", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd       = '{n: n, addr: addr};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("nop_ready_after", 64'(bus.cmd_ready), 64'(1));
        check("nop_no_lookup", 64'(bus.lu_valid), 64'(0));
    endtask

    task automatic run_clear();
        int busy  = 0;
        bit early = 1'b0;
        @(negedge clk);
        check("clear_ready_before", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd       = '{n: CLEAR, addr: $urandom};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (!bus.cmd_ready && busy < SETS + 16) begin
            if (bus.clear_done) early = 1'b1;
            busy++;
            @(negedge clk);
        end
        check("clear_busy_cycles", 64'(busy), 64'(SETS));
        check("clear_done_pulse", 64'(bus.clear_done), 64'(1));
        check("clear_done_early", 64'(early), 64'(0));
        @(negedge clk);
        check("clear_done_width", 64'(bus.clear_done), 64'(0));
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        h, hm;
        logic [2:0]  w;
        cache_line_t ln;
        logic [31:0] fill_addr [7];
        logic [13:0] set_pool  [4];
        logic [31:0] addr;
        logic [3:0]  code;
        int          r;

        fill_addr = '{32'h116DE12F, 32'h100DE130, 32'h999DE12E, 32'h645DE10A,
                      32'h846DE107, 32'h211DE128, 32'h777DE133};
        set_pool  = '{14'h3784, 14'h0000, 14'h3FFF, 14'h0001};
        bus.cmd_valid   = 1'b0;
        bus.cmd         = '0;
        bus.wb_valid    = 1'b0;
        bus.return_line = '0;

        apply_reset();
        check("model_pin_empty_victim", 64'(model_victim(14'h3784)), 64'(0));

        run_cmd(READ, 32'h984DE132, 0, E, h, hm, w, ln);
        check("first_read_hit", 64'(h), 64'(0));
        check("first_read_way", 64'(w), 64'(0));
        check("model_pin_tag", 64'(m_tag[14'h3784][0]), 64'h984);
        check("model_pin_state", 64'(m_state[14'h3784][0]), 64'(E));

        for (int i = 0; i < 7; i++) begin
            run_cmd(READ, fill_addr[i], 0, E, h, hm, w, ln);
            check("fill_hit", 64'(h), 64'(0));
            check("fill_way", 64'(w), 64'(i + 1));
        end
        check("model_pin_full_victim", 64'(model_victim(14'h3784)), 64'(0));

        run_cmd(READ, 32'h123DE100, 1, E, h, hm, w, ln);
        check("victim_hit", 64'(h), 64'(0));
        check("victim_way", 64'(w), 64'(0));
        check("victim_line_tag", 64'(ln.tag), 64'h984);

        run_cmd(READ, 32'h645DE10A, 0, M, h, hm, w, ln);
        check("hit_e_hit", 64'(h), 64'(1));
        check("hit_e_hitM", 64'(hm), 64'(0));
        check("hit_e_way", 64'(w), 64'(4));
        run_cmd(WRITE, 32'h645DE10A, 0, M, h, hm, w, ln);
        check("hit_m_hitM", 64'(hm), 64'(1));
        check("hit_m_way", 64'(w), 64'(4));

        run_cmd(SNOOP_INV, 32'h984DE132, 0, I, h, hm, w, ln);
        check("snoop_hit", 64'(h), 64'(1));
        check("snoop_way", 64'(w), 64'(0));
        run_cmd(READ, 32'hABCDE100, 0, S, h, hm, w, ln);
        check("refill_hit", 64'(h), 64'(0));
        check("refill_way", 64'(w), 64'(0));

        run_nop(PRINT, 32'h984DE132);
        run_nop(4'd7, 32'h984DE132);
        run_nop(4'd15, 32'h984DE132);

        for (int k = 0; k < 300; k++) begin
            addr = {12'(256 + 273 * $urandom_range(0, 11)),
                    set_pool[$urandom_range(0, 3)], 6'($urandom)};
            r = $urandom_range(0, 19);
            if (r < 12) begin
                code = 4'(r % 3);
                run_cmd(code, addr, ($urandom_range(0, 7) == 0) ? 1 : 0,
                        mesi_t'($urandom_range(0, 3)), h, hm, w, ln);
            end else if (r < 18) begin
                code = 4'((r - 12) % 4 + 3);
                run_cmd(code, addr, 2, ($urandom_range(0, 1) == 0) ? I : S, h, hm, w, ln);
            end else if (r == 18) begin
                run_nop(PRINT, addr);
            end else begin
                run_nop(4'($urandom_range(10, 15)), addr);
            end
        end

        run_clear();
        run_cmd(READ, 32'h777DE133, 0, E, h, hm, w, ln);
        check("post_clear_hit", 64'(h), 64'(0));
        check("post_clear_way", 64'(w), 64'(0));
        check("post_clear_line", 64'(ln), 64'(0));
        run_cmd(READ, 32'h645DE10A, 0, M, h, hm, w, ln);

        // reset in the middle of a sweep that has not yet reached set 0x3784
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd       = '{n: CLEAR, addr: 32'h0};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("sweep_busy", 64'(bus.cmd_ready), 64'(0));
        apply_reset();
        run_cmd(READ, 32'h645DE10A, 0, E, h, hm, w, ln);
        check("after_reset_hit", 64'(h), 64'(0));
        check("after_reset_way", 64'(w), 64'(0));
        check("after_reset_line", 64'(ln), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_set_lookup.md
# cache_set_lookup

Tag-lookup and replacement stage directly upstream of `mesi_fsm` in the cache model. It accepts one trace command at a time and indexes the set. It compares tags across all ways, then presents `hit`, `hitM`, the selected way and its current line to `mesi_fsm`. It then writes the returned line back into the set array and updates that set's tree pseudo-LRU bits. It owns the tag/state/PLRU storage and executes the clear command (code 8) as a set-by-set sweep.

## Interface
- `WAYS`, default 8: associativity; power of two, ≥2.
- `IDX_W`, default 14: set index bits; number of sets is 2^IDX_W.
- `TAG_W`, default 12: tag bits.
- `OFF_W`, default 6: byte-offset bits; TAG_W+IDX_W+OFF_W = 32.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: `cmd` holds a command.
- `cmd_ready`, output, 1: block can accept a command.
- `cmd`, input, `command_t`: code `n` plus 32-bit address.
- `lu_valid`, output, 1: lookup result presented to `mesi_fsm`.
- `hit`, output, 1: a valid way matched the tag.
- `hitM`, output, 1: the matching way is in state M.
- `way`, output, $clog2(WAYS): hit way, or the fill/victim way on a miss.
- `internal_line`, output, `cache_line_t`: stored line at [index][way].
- `wb_valid`, input, 1: `return_line` is valid; it is sampled only while `lu_valid`=1.
- `return_line`, input, `cache_line_t`: updated line from `mesi_fsm`.
- `clear_done`, output, 1: one-cycle pulse when a clear sweep finishes.

## Operation
- States: IDLE, LOOKUP, PRESENT, CLEAR.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, capture `cmd`.
  - n=8 goes to CLEAR.
  - n=9 is acknowledged and ignored; stay in IDLE.
  - Codes 0–6 go to LOOKUP.
  - Any other code is dropped; stay in IDLE.
- LOOKUP (one cycle):
  - Index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[31:32-TAG_W].
  - Match = tag equal and state ≠ I.
  - Hit: `way` is the lowest-index matching way.
  - Miss: `way` is the lowest-index I way; if there is none, the PLRU victim.
  - Register all results and go to PRESENT.
- PRESENT:
  - `lu_valid`=1; `hit`, `hitM`, `way` and `internal_line` are held stable.
  - On `wb_valid`, write `return_line` into [index][way] and return to IDLE.
  - PLRU update on write-back: only for codes 0–2 and only when the written state ≠ I. Snoops (3–6) never touch PLRU.
- CLEAR:
  - A counter walks sets 0..2^IDX_W−1, one set per cycle.
  - Each set gets all ways to I, tags 0 and PLRU 0.
  - After the last set: pulse `clear_done` and go to IDLE.
- PLRU encoding:
  - WAYS−1 bits per set, heap-ordered tree.
  - Node bit 0 means the victim lies in the lower half.
  - Access to way w sets each node on w's path to point away from w.
  - All-zero PLRU gives victim way 0.

## Timing
- Reset values:
  - State IDLE; `cmd_ready`=1 once `rst` deasserts.
  - `lu_valid`, `hit`, `hitM`, `clear_done` = 0; `way` = 0; `internal_line` = 0.
  - All lines I with tag 0; all PLRU bits 0.
- Command accepted at edge E0 (`cmd_valid`&&`cmd_ready`).
- `lu_valid` rises after edge E1.
- Write-back happens at the first edge where `lu_valid`&&`wb_valid`; `cmd_ready` is 1 in the following cycle.
- Minimum 3 cycles per lookup command.
- `cmd_ready`=0 in LOOKUP, PRESENT and CLEAR.
- A clear takes 2^IDX_W cycles plus the accept cycle.
- `wb_valid` outside PRESENT is ignored.
- Back-to-back commands to the same set see the prior write-back; there is no bypass hazard because the block is single-outstanding.
- `rst` asserted mid-operation: the pending command and any partial clear are abandoned, and the array is reinitialised.

## Structure
- `my_struct_package` holds:
  - `command_t`, with a 4-bit `n`;
  - `cache_line_t` (tag, mesi);
  - `mesi_t`;
  - command-code constants (READ=0, WRITE=1, IFETCH=2, SNOOP_INV=3, SNOOP_RD=4, SNOOP_WR=5, SNOOP_RWIM=6, CLEAR=8, PRINT=9).
- Sub-module `plru_tree`: combinational victim select plus next-PLRU computation from (plru bits, accessed way); parameter WAYS.

## Test plan
- Reset, then read 0x984DE132 with the bench returning state E → `hit`=0, `way`=0, `lu_valid` after 2 edges. The write stores tag 0x984 in set 0x3784, way 0.
- Reads to 116DE12F, 100DE130, 999DE12E, 645DE10A, 846DE107, 211DE128, 777DE133, each returned E → fills ways 1..7 of set 0x3784.
- Read 0x123DE100 after that fill → `hit`=0, `way`=0 (PLRU victim); `internal_line.tag`=0x984.
- Read 0x645DE10A → `hit`=1, `hitM`=0, `way`=4. Return M, then read it again → `hitM`=1.
- Snoop invalidate (n=3) on 0x984DE132 returning I → the line becomes I. PLRU is unchanged, and the next miss in that set fills that now-invalid way.
- Clear (n=8) with IDX_W=4 → `cmd_ready`=0 for 16 cycles, then a `clear_done` pulse. A following read of 0x777DE133 → `hit`=0, `way`=0.
